// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the writeback path.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned SELECT_LEN = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [SELECT_LEN-1:0] reg_sel_t;
  typedef logic [XLEN-1:0]       xword_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant generator: first requester at or after ptr, with wrap-around.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic [IDX_W-1:0] gnt_idx_c
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_c     = '0;
    gnt_idx_c = '0;
    found     = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        gnt_c[j]  = 1'b1;
        gnt_idx_c = IDX_W'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register array write port among NUM_REQ writeback requesters.
// Optional perf counters are enabled with `define WB_ARB_PERF_EN.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned XLEN       = regfile_pkg::XLEN,
  parameter int unsigned SELECT_LEN = regfile_pkg::SELECT_LEN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*SELECT_LEN-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]      req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [SELECT_LEN-1:0]        store,
  output logic [XLEN-1:0]              store_value,
  output logic                         wb_busy
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                  perf_conflicts,
  output logic [31:0]                  perf_x0_drops
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SELECT_LEN-1:0] store_q, store_d;
  logic [XLEN-1:0]       store_value_q, store_value_d;
  logic                  wb_busy_q, wb_busy_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  accept;
  logic [SELECT_LEN-1:0] win_rd;
  logic [XLEN-1:0]       win_data;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .gnt_c     (gnt),
    .gnt_idx_c (gnt_idx)
  );

  // Grant is suppressed during reset so nothing is accepted on the reset edge.
  always_comb begin
    req_ready = reset ? '0 : gnt;
    accept    = |req_ready;
    win_rd    = req_rd[32'(gnt_idx)*SELECT_LEN +: SELECT_LEN];
    win_data  = req_data[32'(gnt_idx)*XLEN +: XLEN];
  end

  always_comb begin
    store_d       = '0;
    store_value_d = '0;
    rr_ptr_d      = rr_ptr_q;
    if (accept) begin
      store_d       = win_rd;
      store_value_d = win_data;
      rr_ptr_d      = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : IDX_W'(gnt_idx + 1'b1);
    end
    wb_busy_d = (store_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      store_q       <= '0;
      store_value_q <= '0;
      wb_busy_q     <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      store_q       <= store_d;
      store_value_q <= store_value_d;
      wb_busy_q     <= wb_busy_d;
    end
  end

  assign store       = store_q;
  assign store_value = store_value_q;
  assign wb_busy     = wb_busy_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflicts_q, perf_conflicts_d;
  logic [31:0] perf_x0_drops_q, perf_x0_drops_d;

  // Saturating counters; a conflict is any cycle with two or more valids.
  always_comb begin
    perf_conflicts_d = perf_conflicts_q;
    perf_x0_drops_d  = perf_x0_drops_q;
    if (((req_valid & (req_valid - 1'b1)) != '0) && (perf_conflicts_q != 32'hFFFF_FFFF))
      perf_conflicts_d = perf_conflicts_q + 32'd1;
    if (accept && (win_rd == '0) && (perf_x0_drops_q != 32'hFFFF_FFFF))
      perf_x0_drops_d = perf_x0_drops_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflicts_q <= '0;
      perf_x0_drops_q  <= '0;
    end else begin
      perf_conflicts_q <= perf_conflicts_d;
      perf_x0_drops_q  <= perf_x0_drops_d;
    end
  end

  assign perf_conflicts = perf_conflicts_q;
  assign perf_x0_drops  = perf_x0_drops_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (3 requesters).
module tb_regfile_wb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned XW = 32;
  localparam int unsigned SW = 5;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*SW-1:0] req_rd;
  logic [NR*XW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [SW-1:0]    store;
  logic [XW-1:0]    store_value;
  logic             wb_busy;
`ifdef WB_ARB_PERF_EN
  logic [31:0]      perf_conflicts;
  logic [31:0]      perf_x0_drops;
`endif

  int total;
  int bad;

  regfile_wb_arbiter #(
    .NUM_REQ    (NR),
    .XLEN       (XW),
    .SELECT_LEN (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .store       (store),
    .store_value (store_value),
    .wb_busy     (wb_busy)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts),
    .perf_x0_drops  (perf_x0_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [SW-1:0] rd, input logic [XW-1:0] data);
    req_rd[i*SW +: SW]   = rd;
    req_data[i*XW +: XW] = data;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;

    // 1: reset behaviour
    #1;
    req_valid = 3'b111;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    step();
    step();
    check("rst_store", 32'(store), 32'h0);
    check("rst_busy", 32'(wb_busy), 32'h0);
    req_valid = '0;
    reset     = 1'b0;
    step();
    check("idle_store", 32'(store), 32'h0);
    check("idle_ready", 32'(req_ready), 32'h0);

    // 2: single write from req0
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("single_store", 32'(store), 32'd5);
    check("single_value", store_value, 32'hDEAD_BEEF);
    check("single_busy", 32'(wb_busy), 32'h1);
    step();
    check("single_clear", 32'(store), 32'h0);
    check("single_idle_busy", 32'(wb_busy), 32'h0);

    // 3: three continuous requesters from a fresh pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, SW'(i + 1), 32'h100 + 32'(i));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
      step();
      check($sformatf("rr_store%0d", k), 32'(store), 32'((k % 3) + 1));
      check($sformatf("rr_value%0d", k), store_value, 32'h100 + 32'(k % 3));
    end
    req_valid = '0;

    // 4: x0 write completes handshake but produces no store
    set_req(1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    #1;
    check("x0_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check("x0_store", 32'(store), 32'h0);
    check("x0_busy", 32'(wb_busy), 32'h0);
`ifdef WB_ARB_PERF_EN
    check("x0_perf", perf_x0_drops, 32'd1);
`endif

    // 5: back-to-back writes to rd 7 (pointer now at 2)
    set_req(2, 5'd7, 32'hAAAA);
    set_req(0, 5'd7, 32'h5555);
    req_valid = 3'b101;
    #1;
    check("b2b_ready0", 32'(req_ready), 32'h4);
    step();
    req_valid = 3'b001;
    check("b2b_store0", 32'(store), 32'd7);
    check("b2b_value0", store_value, 32'hAAAA);
    check("b2b_ready1", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("b2b_store1", 32'(store), 32'd7);
    check("b2b_value1", store_value, 32'h5555);

    // 6: reset right after accepting rd 9 (pointer now at 1)
    set_req(1, 5'd9, 32'h99);
    req_valid = 3'b010;
    #1;
    check("rstmid_ready", 32'(req_ready), 32'h2);
    step();
    check("rstmid_store", 32'(store), 32'd9);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, SW'(i + 1), 32'h100 + 32'(i));
    req_valid = 3'b111;
    #1;
    check("rstmid_ready_low", 32'(req_ready), 32'h0);
    step();
    check("rstmid_dropped", 32'(store), 32'h0);
    check("rstmid_busy", 32'(wb_busy), 32'h0);
    reset = 1'b0;
    #1;
    check("rstmid_ptr0", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("rstmid_first", 32'(store), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
